// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
//
// Purpose:
//   Streams a raster-order image in and produces 3x3 sliding windows for a
//   convolution engine. Two line buffers hold the two previous rows. A 3x3
//   register window shifts left by one column on every accepted pixel. A
//   window is presented only when all nine taps belong to the current frame,
//   so each frame yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows with no edge
//   padding.
//
// Parameters:
//   DATA_WIDTH  - pixel width in bits
//   KERNEL_SIZE - window edge (only 3 supported)
//   IMG_WIDTH   - pixels per row   (3..1024)
//   IMG_HEIGHT  - rows per frame   (3..1024)
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   pix_in      in   raster-order pixel
//   pix_valid   in   pix_in valid
//   pix_sof     in   start of frame (qualified by pix_valid)
//   pix_ready   out  pixel accepted when pix_valid && pix_ready
//   window      out  3x3 window, tap k=r*3+c at [k*DATA_WIDTH +: DATA_WIDTH],
//                    r=0 oldest row, c=0 leftmost column
//   win_valid   out  window valid
//   win_ready   in   downstream consumes window when win_valid && win_ready
//   frame_done  out  one-cycle pulse after the last pixel of a frame
//   frame_count out  (only with CONV_WIN_FRAME_CNT_EN) 16-bit wrapping count
//                    of frame_done pulses
//
// Optional feature macro: CONV_WIN_FRAME_CNT_EN
// ---------------------------------------------------------------------------
module conv_window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [DATA_WIDTH-1:0]                      pix_in,
  input  logic                                       pix_valid,
  input  logic                                       pix_sof,
  output logic                                       pix_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window,
  output logic                                       win_valid,
  input  logic                                       win_ready,
  output logic                                       frame_done
`ifdef CONV_WIN_FRAME_CNT_EN
  ,
  output logic [15:0]                                frame_count
`endif
);

  localparam int K    = KERNEL_SIZE;
  localparam int NTAP = K * K;
  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int RW   = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {
    PRIME = 1'b0,  // rows 0 and 1: line buffers still filling
    RUN   = 1'b1   // row >= 2: full windows possible
  } state_e;

  // Registered state
  state_e                             state_q, state_d;
  logic [CW-1:0]                      col_q, col_d;
  logic [RW-1:0]                      row_q, row_d;
  logic [NTAP-1:0][DATA_WIDTH-1:0]    win_q, win_d;
  logic                               win_valid_q, win_valid_d;
  logic                               frame_done_q, frame_done_d;

  // Line buffers: no reset needed, every tap that reaches a valid window
  // was written earlier in the same frame.
  logic [DATA_WIDTH-1:0] lb_top [IMG_WIDTH];  // row-2
  logic [DATA_WIDTH-1:0] lb_mid [IMG_WIDTH];  // row-1

  // Effective position/state of the pixel on the input: a start-of-frame
  // pixel is forced to (0,0) in PRIME regardless of the counters.
  logic [CW-1:0] ecol;
  logic [RW-1:0] erow;
  state_e        estate;
  logic          accept;
  logic          col_end;
  logic          row_end;
  logic [DATA_WIDTH-1:0] top_rd;
  logic [DATA_WIDTH-1:0] mid_rd;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

  always_comb begin
    ecol   = col_q;
    erow   = row_q;
    estate = state_q;
    if (pix_sof) begin
      ecol   = '0;
      erow   = '0;
      estate = PRIME;
    end
  end

  assign col_end = (ecol == COL_LAST);
  assign row_end = (erow == ROW_LAST);
  assign top_rd  = lb_top[ecol];
  assign mid_rd  = lb_mid[ecol];

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;

    if (accept) begin
      // Raster counters
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : erow + 1'b1;
      end else begin
        col_d = ecol + 1'b1;
        row_d = erow;
      end

      // Row 1 complete -> both line buffers hold frame data.
      // Last row complete -> next pixel starts a new frame.
      state_d = estate;
      if (col_end && (erow == RW'(1))) state_d = RUN;
      if (col_end && row_end)          state_d = PRIME;

      // Shift window left; new right column is (row-2, row-1, current)
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r*K + c] = win_q[r*K + c + 1];
        end
      end
      win_d[K-1]   = top_rd;
      win_d[2*K-1] = mid_rd;
      win_d[3*K-1] = pix_in;

      // Columns 0/1 of a row would mix in taps from the previous row's tail
      win_valid_d  = (estate == RUN) && (ecol >= CW'(2));
      frame_done_d = col_end && row_end;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PRIME;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer column update: top takes the old middle, middle takes the
  // incoming pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[ecol] <= mid_rd;
      lb_mid[ecol] <= pix_in;
    end
  end

  assign window     = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

`ifdef CONV_WIN_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Wraps naturally at 16 bits
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_done_q) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_count_q <= '0;
    else     frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  typedef logic [9*DW-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_ready;
  win_t          window;
  logic          win_valid;
  logic          win_ready;
  logic          frame_done;
`ifdef CONV_WIN_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  always #5 clk = ~clk;

  conv_window_gen #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(3),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .window     (window),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
`ifdef CONV_WIN_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input win_t act, input win_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: frame image + position ----------------
  win_t          exp_q[$];
  logic [DW-1:0] img [H][W];
  int            m_row = 0, m_col = 0;
  int            fd_exp_cnt = 0;
  int            fd_since_rst = 0;
  logic          cur_last = 1'b0;

  function automatic void model_accept(input logic [DW-1:0] v, input bit sof);
    win_t w;
    if (sof) begin m_row = 0; m_col = 0; end
    img[m_row][m_col] = v;
    if (m_row >= 2 && m_col >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[(i*3+j)*DW +: DW] = img[m_row-2+i][m_col-2+j];
      exp_q.push_back(w);
    end
    if (m_row == H-1 && m_col == W-1) begin
      fd_exp_cnt++;
      fd_since_rst++;
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end
  endfunction

  // ---------------- drivers ----------------
  bit stall_req  = 0;
  bit rand_ready = 0;

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_req && win_valid) begin
        win_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        win_ready = 1'b1;
        stall_req = 0;
      end else if (rand_ready) begin
        win_ready = ($urandom_range(0, 3) != 0);
      end else begin
        win_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [DW-1:0] v, input bit sof, input int gap);
    int  r, c, n;
    bit  rdy;
    r = sof ? 0 : m_row;
    c = sof ? 0 : m_col;
    pix_in    = v;
    pix_sof   = sof;
    pix_valid = 1'b1;
    cur_last  = (r == H-1 && c == W-1);
    n = 0;
    do begin
      @(negedge clk);
      rdy = pix_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      $display("FAIL accept_timeout: pixel %0d not accepted within %0d cycles", v, n);
    end else begin
      model_accept(v, sof);
    end
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    cur_last  = 1'b0;
    pix_in    = DW'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // mode 0: ramp (row*W+col), mode 1: random; gap<0: random 0..2 idle cycles
  task automatic send_frame(input int mode, input bit sof_first, input int gap);
    logic [DW-1:0] v;
    int g;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        v = (mode == 0) ? DW'(r*W + c) : DW'($urandom);
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        send(v, sof_first && r == 0 && c == 0, g);
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_row = 0;
    m_col = 0;
    fd_since_rst = 0;
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  bit   prev_rst  = 0;
  bit   prev_last = 0;
  bit   prev_hold = 0;
  win_t prev_win;
  int   fd_seen = 0;

  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_win_valid", win_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_window", window, 0);
    end else begin
      chk("frame_done", frame_done, prev_last);
      if (prev_hold) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_window", window, prev_win);
      end
    end
    if (frame_done === 1'b1) fd_seen++;
    chk("pix_ready", pix_ready, (!win_valid || win_ready));
    if (win_valid === 1'b1 && win_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL window_unexpected: got %h expected none", window);
      end else begin
        chk("window", window, exp_q.pop_front());
      end
    end
    prev_hold = (win_valid === 1'b1) && !win_ready;
    prev_win  = window;
    prev_rst  = rst;
    prev_last = pix_valid && pix_ready && cur_last && !rst;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    pix_in    = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Ramp frame, always ready
    send_frame(0, 1, 0);

    // Ramp frame with a 3-cycle downstream stall on the first window
    stall_req = 1;
    send_frame(0, 1, 0);

    // Abort partial frame with sof at (2,1), then full ramp frame
    for (int i = 0; i < 11; i++) send(DW'(i), i == 0, 0);
    send(DW'(11), 1, 0);
    send_frame(0, 1, 0);

    // Reset right after pixel (2,3); following frame has no sof
    for (int i = 0; i < 14; i++) send(DW'(i), i == 0, 0);
    do_reset();
    send_frame(0, 0, 0);

    // Two back-to-back frames after reset
    do_reset();
    send_frame(0, 1, 0);
    send_frame(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
`ifdef CONV_WIN_FRAME_CNT_EN
    chk("frame_count_b2b", frame_count, 2);
`endif

    // pix_valid every other cycle
    send_frame(0, 1, 1);

    // Random pixels, random gaps, random downstream backpressure
    rand_ready = 1;
    for (int f = 0; f < 4; f++) send_frame(1, ($urandom_range(0, 1) == 1), -1);
    rand_ready = 0;

    repeat (10) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("frame_done_count", fd_seen, fd_exp_cnt);
`ifdef CONV_WIN_FRAME_CNT_EN
    chk("frame_count_end", frame_count, 16'(fd_since_rst));
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
